// File: rtl/washer_sensor_cond.sv
// rtl/washer_sensor_cond.sv - washer input conditioning: sync, debounce, pulses, level hysteresis, sensor watchdog
//
// Purpose: conditions raw front-panel, door and humidity inputs and the sampled
// water-level ADC stream into clean levels and single-cycle pulses for the
// washer controller FSM.
//
// Ports:
//   clk              system clock
//   rstn             asynchronous active-low reset
//   btn_start_raw    start button, 1=pressed, asynchronous
//   btn_cancel_raw   cancel button, 1=pressed, asynchronous
//   door_sw_raw      door switch, 1=open, asynchronous
//   humidity_low_raw humidity below dry threshold, asynchronous
//   level_data       water-level ADC sample, synchronous to clk
//   level_valid      one-cycle strobe qualifying level_data
//   start            one-cycle start pulse
//   cancel           one-cycle cancel pulse
//   door_open        conditioned door state (fail-safe open)
//   water_full       drum full, hysteretic level
//   drained          drum empty, hysteretic level
//   dry_sensor       laundry dry level
//   sensor_err       level sensor timeout or open circuit

module washer_sensor_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int DRY_HOLD    = 8,
    parameter int LVL_W       = 8,
    parameter int LVL_FULL    = 200,
    parameter int LVL_EMPTY   = 16,
    parameter int HYST        = 8,
    parameter int LVL_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_start_raw,
    input  logic             btn_cancel_raw,
    input  logic             door_sw_raw,
    input  logic             humidity_low_raw,
    input  logic [LVL_W-1:0] level_data,
    input  logic             level_valid,
    output logic             start,
    output logic             cancel,
    output logic             door_open,
    output logic             water_full,
    output logic             drained,
    output logic             dry_sensor,
    output logic             sensor_err
);

    localparam int NUM_IN     = 4;
    localparam int IDX_START  = 0;
    localparam int IDX_CANCEL = 1;
    localparam int IDX_DOOR   = 2;
    localparam int IDX_HUM    = 3;
    localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
    localparam int DRY_W      = $clog2(DRY_HOLD + 1);
    localparam int WD_W       = $clog2(LVL_TIMEOUT + 1);
    localparam int LW1        = LVL_W + 1;

    // Door resets to "open" everywhere, including its synchroniser, so a
    // closed door has to be observed through the full sync + debounce path.
    localparam logic [NUM_IN-1:0] STABLE_RST = 4'b0100;

    localparam logic [LW1-1:0] FULL_SET  = LW1'(LVL_FULL);
    localparam logic [LW1-1:0] FULL_CLR  = LW1'(LVL_FULL - HYST);
    localparam logic [LW1-1:0] EMPTY_SET = LW1'(LVL_EMPTY);
    localparam logic [LW1-1:0] EMPTY_CLR = LW1'(LVL_EMPTY + HYST);

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] sync_q;
    logic [NUM_IN-1:0] stable_q;
    logic [NUM_IN-1:0] stable_d1;
    logic [NUM_IN-1:0] rise;

    assign raw_vec = {humidity_low_raw, door_sw_raw, btn_cancel_raw, btn_start_raw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        localparam logic [SYNC_STAGES-1:0] PIPE_RST = {SYNC_STAGES{STABLE_RST[i]}};

        logic [SYNC_STAGES-1:0] pipe;
        logic [DEB_W-1:0]       cnt;
        logic                   stab;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pipe <= PIPE_RST;
                cnt  <= '0;
                stab <= STABLE_RST[i];
            end else begin
                pipe <= {pipe[SYNC_STAGES-2:0], raw_vec[i]};
                if (i == IDX_DOOR && pipe[SYNC_STAGES-1]) begin
                    // Opening is taken immediately; only closing is debounced.
                    stab <= 1'b1;
                    cnt  <= '0;
                end else if (pipe[SYNC_STAGES-1] == stab) begin
                    cnt <= '0;
                end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    // This is the DEB_CYCLES-th consecutive differing cycle.
                    stab <= pipe[SYNC_STAGES-1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign sync_q[i]   = pipe[SYNC_STAGES-1];
        assign stable_q[i] = stab;
    end

    assign rise      = stable_q & ~stable_d1;
    assign door_open = stable_q[IDX_DOOR] | sync_q[IDX_DOOR];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_d1 <= STABLE_RST;
            start     <= 1'b0;
            cancel    <= 1'b0;
        end else begin
            stable_d1 <= stable_q;
            cancel    <= rise[IDX_CANCEL];
            // A simultaneous cancel wins because its stable value is already 1.
            start     <= rise[IDX_START] & ~door_open & ~stable_q[IDX_CANCEL];
        end
    end

    logic [DRY_W-1:0] dry_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dry_cnt <= '0;
        end else if (!stable_q[IDX_HUM]) begin
            dry_cnt <= '0;
        end else if (dry_cnt != DRY_W'(DRY_HOLD)) begin
            dry_cnt <= dry_cnt + 1'b1;
        end
    end

    assign dry_sensor = (dry_cnt == DRY_W'(DRY_HOLD));

    logic [LW1-1:0] sample_ext;
    logic           sample_open;
    logic [WD_W-1:0] wd_cnt;

    assign sample_ext  = {1'b0, level_data};
    assign sample_open = &level_data;

    // Full/drained only move on a good sample; every path that raises
    // sensor_err also forces them low, so they stay low while it is set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt     <= '0;
            sensor_err <= 1'b0;
            water_full <= 1'b0;
            drained    <= 1'b0;
        end else if (level_valid) begin
            wd_cnt <= '0;
            if (sample_open) begin
                sensor_err <= 1'b1;
                water_full <= 1'b0;
                drained    <= 1'b0;
            end else begin
                sensor_err <= 1'b0;
                if (sample_ext >= FULL_SET) begin
                    water_full <= 1'b1;
                end else if (sample_ext < FULL_CLR) begin
                    water_full <= 1'b0;
                end
                if (sample_ext <= EMPTY_SET) begin
                    drained <= 1'b1;
                end else if (sample_ext > EMPTY_CLR) begin
                    drained <= 1'b0;
                end
            end
        end else if (wd_cnt >= WD_W'(LVL_TIMEOUT - 1)) begin
            wd_cnt     <= WD_W'(LVL_TIMEOUT);
            sensor_err <= 1'b1;
            water_full <= 1'b0;
            drained    <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_washer_sensor_cond.sv
// tb/tb_washer_sensor_cond.sv - self-checking bench for washer_sensor_cond

module tb_washer_sensor_cond;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int DRYH  = 8;
    localparam int FULL  = 200;
    localparam int EMPTY = 16;
    localparam int HYS   = 8;
    localparam int TMO   = 1000;

    logic       clk;
    logic       rstn;
    logic       btn_start_raw;
    logic       btn_cancel_raw;
    logic       door_sw_raw;
    logic       humidity_low_raw;
    logic [7:0] level_data;
    logic       level_valid;
    logic       start;
    logic       cancel;
    logic       door_open;
    logic       water_full;
    logic       drained;
    logic       dry_sensor;
    logic       sensor_err;

    int checks;
    int failures;

    washer_sensor_cond dut (
        .clk              (clk),
        .rstn             (rstn),
        .btn_start_raw    (btn_start_raw),
        .btn_cancel_raw   (btn_cancel_raw),
        .door_sw_raw      (door_sw_raw),
        .humidity_low_raw (humidity_low_raw),
        .level_data       (level_data),
        .level_valid      (level_valid),
        .start            (start),
        .cancel           (cancel),
        .door_open        (door_open),
        .water_full       (water_full),
        .drained          (drained),
        .dry_sensor       (dry_sensor),
        .sensor_err       (sensor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 start, 1 cancel, 2 door, 3 humidity.
    bit [SYNC-1:0] m_pipe [4];
    bit  m_stab [4];
    bit  m_last [4];
    int  m_run  [4];
    bit  m_start_rose, m_cancel_rose;
    int  m_hum_edges, m_idle;
    bit  m_start, m_cancel, m_full, m_drained, m_err;

    always @(posedge clk or negedge rstn) begin
        bit pre_s [4];
        bit pre_b [4];
        bit raw   [4];
        bit pre_door;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                m_pipe[i] = (i == 2) ? '1 : '0;
                m_stab[i] = (i == 2);
                m_last[i] = (i == 2);
                m_run[i]  = 0;
            end
            m_start_rose = 0; m_cancel_rose = 0;
            m_hum_edges = 0; m_idle = 0;
            m_start = 0; m_cancel = 0; m_full = 0; m_drained = 0; m_err = 0;
        end else begin
            raw[0] = btn_start_raw;
            raw[1] = btn_cancel_raw;
            raw[2] = door_sw_raw;
            raw[3] = humidity_low_raw;
            for (int i = 0; i < 4; i++) begin
                pre_s[i] = m_pipe[i][SYNC-1];
                pre_b[i] = m_stab[i];
            end
            pre_door = pre_b[2] | pre_s[2];
            m_cancel = m_cancel_rose;
            m_start  = m_start_rose && !pre_door && !pre_b[1];
            // Stable follows the synchronised waveform once it has held a new
            // value for DEB consecutive cycles; door opening is immediate.
            for (int i = 0; i < 4; i++) begin
                m_run[i]  = (pre_s[i] == m_last[i]) ? ((m_run[i] < 100000) ? m_run[i] + 1 : m_run[i]) : 1;
                m_last[i] = pre_s[i];
                if (i == 2 && pre_s[i]) m_stab[i] = 1;
                else if (pre_s[i] != m_stab[i] && m_run[i] >= DEB) m_stab[i] = pre_s[i];
                m_pipe[i] = {m_pipe[i][SYNC-2:0], raw[i]};
            end
            m_start_rose  = !pre_b[0] && m_stab[0];
            m_cancel_rose = !pre_b[1] && m_stab[1];
            m_hum_edges   = pre_b[3] ? ((m_hum_edges < 100000) ? m_hum_edges + 1 : m_hum_edges) : 0;
            if (level_valid) begin
                m_idle = 0;
                if (level_data == 8'hFF) begin
                    m_err = 1; m_full = 0; m_drained = 0;
                end else begin
                    m_err = 0;
                    if (int'(level_data) >= FULL) m_full = 1;
                    else if (int'(level_data) < FULL - HYS) m_full = 0;
                    if (int'(level_data) <= EMPTY) m_drained = 1;
                    else if (int'(level_data) > EMPTY + HYS) m_drained = 0;
                end
            end else begin
                if (m_idle < TMO) m_idle++;
                if (m_idle >= TMO) begin
                    m_err = 1; m_full = 0; m_drained = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("start", start, m_start);
            chk("cancel", cancel, m_cancel);
            chk("door_open", door_open, m_stab[2] | m_pipe[2][SYNC-1]);
            chk("water_full", water_full, m_full);
            chk("drained", drained, m_drained);
            chk("dry_sensor", dry_sensor, m_hum_edges >= DRYH);
            chk("sensor_err", sensor_err, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic lvl(input logic [7:0] v);
        level_data  = v;
        level_valid = 1'b1;
        @(negedge clk);
        level_valid = 1'b0;
    endtask

    int first, ps, pc;
    int full_in  [5] = '{150, 200, 195, 191, 150};
    int full_exp [5] = '{0, 1, 1, 0, 0};
    int drn_in   [4] = '{30, 16, 22, 25};
    int drn_exp  [4] = '{0, 1, 1, 0};

    initial begin
        checks = 0; failures = 0;
        btn_start_raw = 0; btn_cancel_raw = 0; door_sw_raw = 0; humidity_low_raw = 0;
        level_data = 0; level_valid = 0; rstn = 0;
        repeat (3) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_cancel", cancel, 0);
        chk("rst_door_open", door_open, 1);
        chk("rst_water_full", water_full, 0);
        chk("rst_drained", drained, 0);
        chk("rst_dry", dry_sensor, 0);
        chk("rst_err", sensor_err, 0);
        rstn = 1;

        // door closed from reset: open for 6 cycles, reads closed on the 6th sample
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first == 0 && !door_open) first = k;
        end
        chk("door_close_cycles", first, 6);

        // one-cycle open glitch is seen within SYNC cycles
        first = 0;
        door_sw_raw = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) door_sw_raw = 0;
            if (first == 0 && door_open) first = k;
        end
        chk("door_glitch_cycles", first, 2);
        repeat (12) @(negedge clk);
        chk("door_reclosed", door_open, 0);

        // bouncing start then hold: one pulse, 7 cycles after the final rise
        btn_start_raw = 1; @(negedge clk);
        btn_start_raw = 0; @(negedge clk);
        btn_start_raw = 1;
        ps = 0; first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (start) begin
                ps++;
                if (first == 0) first = k;
            end
        end
        chk("start_pulses", ps, 1);
        chk("start_latency", first, 7);
        btn_start_raw = 0;
        repeat (10) @(negedge clk);

        // door open: start press is swallowed
        door_sw_raw = 1;
        repeat (4) @(negedge clk);
        btn_start_raw = 1;
        ps = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (start) ps++;
        end
        chk("start_door_open", ps, 0);
        btn_start_raw = 0;
        repeat (10) @(negedge clk);
        door_sw_raw = 0;
        repeat (10) @(negedge clk);

        // start and cancel together: only cancel
        btn_start_raw = 1; btn_cancel_raw = 1;
        ps = 0; pc = 0; first = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (start) ps++;
            if (cancel) begin
                pc++;
                if (first == 0) first = k;
            end
        end
        chk("both_start", ps, 0);
        chk("both_cancel", pc, 1);
        chk("cancel_latency", first, 7);
        btn_start_raw = 0; btn_cancel_raw = 0;
        repeat (10) @(negedge clk);

        // level hysteresis
        for (int i = 0; i < 5; i++) begin
            lvl(8'(full_in[i]));
            chk($sformatf("water_full_s%0d", full_in[i]), water_full, full_exp[i]);
        end
        for (int i = 0; i < 4; i++) begin
            lvl(8'(drn_in[i]));
            chk($sformatf("drained_s%0d", drn_in[i]), drained, drn_exp[i]);
        end

        // watchdog boundary, open-circuit sample, recovery
        lvl(8'd10);
        chk("wd_pre_drained", drained, 1);
        repeat (TMO - 1) @(negedge clk);
        chk("wd_err_before", sensor_err, 0);
        @(negedge clk);
        chk("wd_err_at", sensor_err, 1);
        chk("wd_drained_forced", drained, 0);
        chk("wd_full_forced", water_full, 0);
        lvl(8'hFF);
        chk("open_err", sensor_err, 1);
        lvl(8'd10);
        chk("recover_err", sensor_err, 0);
        chk("recover_drained", drained, 1);

        // humidity: dry after SYNC+DEB+DRYH cycles, drop 7 cycles after raw falls
        humidity_low_raw = 1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (first == 0 && dry_sensor) first = k;
        end
        chk("dry_assert", first, 14);
        humidity_low_raw = 0;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first == 0 && !dry_sensor) first = k;
        end
        chk("dry_drop", first, 7);

        // short humidity period then a full restart of the count
        ps = 0;
        humidity_low_raw = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (dry_sensor) ps++;
        end
        humidity_low_raw = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (dry_sensor) ps++;
        end
        chk("dry_partial", ps, 0);
        humidity_low_raw = 1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (first == 0 && dry_sensor) first = k;
        end
        chk("dry_restart", first, 14);
        humidity_low_raw = 0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/washer_sensor_cond.md
Name: washer_sensor_cond

Overview:
Input-conditioning front end that sits directly upstream of the washer controller FSM. It synchronises and debounces the front-panel buttons and the door switch, and converts raw panel edges into the single-cycle start/cancel pulses the controller consumes. It also converts sampled water-level ADC readings into hysteretic water_full/drained levels, conditions the humidity sensor into dry_sensor, and flags a dead or open-circuit level sensor.

Parameters:
SYNC_STAGES, 2, synchroniser depth on every raw 1-bit input (min 2)
DEB_CYCLES, 4, consecutive cycles a synchronised input must differ from its stable value before the stable value flips (min 1)
DRY_HOLD, 8, extra consecutive cycles debounced humidity_low must be 1 before dry_sensor asserts
LVL_W, 8, level_data width
LVL_FULL, 200, water_full set threshold (sample >= LVL_FULL)
LVL_EMPTY, 16, drained set threshold (sample <= LVL_EMPTY)
HYST, 8, hysteresis band; requires LVL_EMPTY+HYST < LVL_FULL-HYST
LVL_TIMEOUT, 1000, max cycles between level_valid strobes before sensor_err

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
btn_start_raw  in  1  start button, 1=pressed, async
btn_cancel_raw  in  1  cancel button, 1=pressed, async
door_sw_raw  in  1  door switch, 1=open, async
humidity_low_raw  in  1  drum humidity below dry threshold, async
level_data  in  LVL_W  water-level ADC sample, synchronous to clk
level_valid  in  1  one-cycle strobe qualifying level_data
start  out  1  one-cycle start pulse
cancel  out  1  one-cycle cancel pulse
door_open  out  1  conditioned door state, level
water_full  out  1  drum full, level
drained  out  1  drum empty, level
dry_sensor  out  1  laundry dry, level
sensor_err  out  1  level sensor fault, level

Behaviour:
- Reset (async, rstn=0): start=0, cancel=0, water_full=0, drained=0, dry_sensor=0, sensor_err=0. door_open=1 (fail-safe; the door must be proven closed). All synchronisers, debounce counters, stable values (door stable=1), the dry hold counter and the watchdog are cleared. Reset mid-operation aborts any pending pulse.
- Synchronisers: SYNC_STAGES flops per raw input; no combinational path from raw inputs to outputs.
- Debounce, per input: a counter increments while sync != stable and clears when sync == stable. When the counter reaches DEB_CYCLES, stable takes sync and the counter clears. A glitch shorter than DEB_CYCLES cycles never changes stable. Counter width is clog2(DEB_CYCLES+1); it never wraps.
- start/cancel: registered. Each pulses for exactly 1 cycle, one cycle after the corresponding stable value rises. Latency from a clean raw edge is SYNC_STAGES+DEB_CYCLES+1 cycles. Holding a button produces one pulse only.
- start is suppressed when door_open=1 or the cancel stable value is 1 in the pulse cycle. If start and cancel rise in the same cycle, only cancel pulses.
- door_open: asserts on the first cycle synchronised door=1, with no debounce (fail-safe). It deasserts only through the debounce path, after DEB_CYCLES consecutive closed cycles.
- dry_sensor: a hold counter counts while debounced humidity_low=1 and clears on 0. dry_sensor=1 once the count reaches DRY_HOLD (the counter saturates there). It drops the cycle after debounced humidity_low falls.
- Level path: evaluated only at a clock edge with level_valid=1; outputs are visible the next cycle (latency 1) and hold between strobes.
  - water_full: set if sample >= LVL_FULL; cleared if sample < LVL_FULL-HYST; otherwise held.
  - drained: set if sample <= LVL_EMPTY; cleared if sample > LVL_EMPTY+HYST; otherwise held.
  - Threshold arithmetic uses LVL_W+1 bits, with no underflow/overflow.
- Watchdog: counter cleared on every level_valid and saturating at LVL_TIMEOUT. sensor_err sets when the count reaches LVL_TIMEOUT. sensor_err also sets on a valid sample equal to all ones (open circuit).
  - sensor_err clears on the next valid sample that is not all ones; that sample updates water_full/drained normally.
  - While sensor_err=1, water_full and drained are forced 0 and held 0.

Test Plan:
- Reset then door_sw_raw=0 held → door_open stays 1 for SYNC_STAGES+DEB_CYCLES cycles (6 at defaults), then 0. During a later closed period, a 1-cycle door_sw_raw=1 glitch → door_open=1 within SYNC_STAGES cycles.
- Door closed, btn_start_raw bounces 1/0/1 (1-cycle spans) then holds 1 for 20 cycles → exactly one start pulse, 7 cycles after the final rising edge. No pulse occurs while door_open=1.
- btn_start_raw and btn_cancel_raw rise in the same cycle and are held → one cancel pulse, start never pulses.
- level_valid samples 150, 200, 195, 191, 150 → water_full 0,1,1,0,0. Samples 30, 16, 22, 25 → drained 0,1,1,0.
- No level_valid for 1000 cycles → sensor_err=1, water_full=drained=0. Next sample 0xFF → sensor_err stays 1. Next sample 10 → sensor_err=0 and drained=1 one cycle later.
- humidity_low_raw held 1 → dry_sensor=1 after SYNC_STAGES+DEB_CYCLES+DRY_HOLD cycles. A drop mid-hold restarts the full count.
